// File: rtl/video_bar_pattern_gen_if.sv
// AXI4-Stream video bundle carried between the colour-bar source and its sink.
// The master side drives the beat; the slave side drives tready only.
interface video_bar_pattern_gen_if;
  logic        tready;
  logic        tvalid;
  logic [31:0] tdata;
  logic        tuser;
  logic        tlast;
  logic [3:0]  tkeep;
  logic [3:0]  tstrb;
  logic        tid;
  logic        tdest;

  modport master (
    input  tready,
    output tvalid, tdata, tuser, tlast, tkeep, tstrb, tid, tdest
  );

  modport slave (
    output tready,
    input  tvalid, tdata, tuser, tlast, tkeep, tstrb, tid, tdest
  );
endinterface

// File: rtl/video_bar_pattern_gen.sv
// Free-running colour-bar video source on AXI4-Stream, one pixel per beat.
// A raster of (x, y) counters walks active pixels and blanking; the beat is
// decoded straight from the registered counters, so there is no pipeline
// latency and a stalled beat holds its data until the sink takes it.
module video_bar_pattern_gen #(
  parameter int unsigned X_ACTIVE   = 1920,
  parameter int unsigned X_BLANKING = 280,
  parameter int unsigned Y_ACTIVE   = 1080,
  parameter int unsigned Y_BLANKING = 45,
  parameter int unsigned PX_WIDTH   = 10
) (
  input  logic                    clk_i,
  input  logic                    rst_n_i,
  video_bar_pattern_gen_if.master video
);

  localparam int unsigned X_TOTAL = X_ACTIVE + X_BLANKING;
  localparam int unsigned Y_TOTAL = Y_ACTIVE + Y_BLANKING;
  localparam int unsigned XW      = $clog2(X_TOTAL);
  localparam int unsigned YW      = $clog2(Y_TOTAL);
  localparam int unsigned BAR_W   = X_ACTIVE / 8;

  localparam logic [XW-1:0] X_ACT_END = XW'(X_ACTIVE);
  localparam logic [XW-1:0] X_ACT_LST = XW'(X_ACTIVE - 1);
  localparam logic [XW-1:0] X_END     = XW'(X_TOTAL - 1);
  localparam logic [YW-1:0] Y_ACT_END = YW'(Y_ACTIVE);
  localparam logic [YW-1:0] Y_END     = YW'(Y_TOTAL - 1);

  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic          run_q, run_d;

  logic          active;
  logic          tvalid;
  logic          advance;
  logic [2:0]    bar_idx;
  logic [2:0]    rgb_on;
  logic [31:0]   pix_data;

  assign active  = (x_q < X_ACT_END) && (y_q < Y_ACT_END);
  assign tvalid  = run_q && active;
  // Active pixels move only on a handshake; blanking free-runs once started.
  assign advance = run_q && (!active || video.tready);

  // Next raster position and the run flag that arms on the first edge after reset.
  always_comb begin
    // NOTE: every output of this block is given a default first so no path
    // leaves it unassigned, which would otherwise infer a latch.
    x_d   = x_q;
    y_d   = y_q;
    run_d = 1'b1;
    if (advance) begin
      if (x_q == X_END) begin
        x_d = '0;
        y_d = (y_q == Y_END) ? '0 : y_q + YW'(1);
      end else begin
        x_d = x_q + XW'(1);
      end
    end
  end

  // Raster state registers; reset parks the stream at (0,0) with output idle.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples its pre-edge inputs regardless of statement order.
    if (!rst_n_i) begin
      x_q   <= '0;
      y_q   <= '0;
      run_q <= 1'b0;
    end else begin
      x_q   <= x_d;
      y_q   <= y_d;
      run_q <= run_d;
    end
  end

  // Bar index from a ladder of comparators; remainder pixels fall into bar 7.
  always_comb begin
    bar_idx = '0;
    for (int k = 1; k < 8; k++) begin
      if (32'(x_q) >= 32'(k) * BAR_W) bar_idx = 3'(k);
    end
  end

  // Which of R, G, B is full scale for each bar, white down to black.
  always_comb begin
    unique case (bar_idx)
      3'd0:    rgb_on = 3'b111; // white
      3'd1:    rgb_on = 3'b110; // yellow
      3'd2:    rgb_on = 3'b011; // cyan
      3'd3:    rgb_on = 3'b010; // green
      3'd4:    rgb_on = 3'b101; // magenta
      3'd5:    rgb_on = 3'b100; // red
      3'd6:    rgb_on = 3'b001; // blue
      default: rgb_on = 3'b000; // black
    endcase
  end

  // Pack R,G,B contiguously from bit 0; the bus reads zero whenever idle.
  always_comb begin
    pix_data = '0;
    if (tvalid) begin
      pix_data[3*PX_WIDTH-1 -: PX_WIDTH] = {PX_WIDTH{rgb_on[2]}};
      pix_data[2*PX_WIDTH-1 -: PX_WIDTH] = {PX_WIDTH{rgb_on[1]}};
      pix_data[PX_WIDTH-1:0]             = {PX_WIDTH{rgb_on[0]}};
    end
  end

  assign video.tvalid = tvalid;
  assign video.tdata  = pix_data;
  assign video.tuser  = tvalid && (x_q == '0) && (y_q == '0);
  assign video.tlast  = tvalid && (x_q == X_ACT_LST);
  assign video.tkeep  = 4'hF;
  assign video.tstrb  = 4'hF;
  assign video.tid    = 1'b0;
  assign video.tdest  = 1'b0;

endmodule

// File: tb/tb_video_bar_pattern_gen.sv
// Bench for the colour-bar source, run on a shrunken raster so whole frames
// fit in a short run: 43 active + 8 blank clocks, 4 active + 2 blank lines.
// Bar width is 5, so pixels 40..42 exercise the remainder-into-black rule.
module tb_video_bar_pattern_gen;

  localparam int XA    = 43;
  localparam int XB    = 8;
  localparam int YA    = 4;
  localparam int YB    = 2;
  localparam int XT    = XA + XB;
  localparam int FRAME = XT * (YA + YB);
  localparam int BW    = 5;

  localparam logic [31:0] WHITE   = 32'h3FFF_FFFF;
  localparam logic [31:0] YELLOW  = 32'h3FFF_FC00;
  localparam logic [31:0] CYAN    = 32'h000F_FFFF;
  localparam logic [31:0] GREEN   = 32'h000F_FC00;
  localparam logic [31:0] MAGENTA = 32'h3FF0_03FF;
  localparam logic [31:0] RED     = 32'h3FF0_0000;
  localparam logic [31:0] BLUE    = 32'h0000_03FF;
  localparam logic [31:0] BLACK   = 32'h0000_0000;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  video_bar_pattern_gen_if vif ();

  video_bar_pattern_gen #(
    .X_ACTIVE  (XA),
    .X_BLANKING(XB),
    .Y_ACTIVE  (YA),
    .Y_BLANKING(YB),
    .PX_WIDTH  (10)
  ) dut (
    .clk_i  (clk),
    .rst_n_i(rst_n),
    .video  (vif)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Expected pixel by division, independent of the DUT's comparator ladder.
  function automatic logic [31:0] exp_pix(input int x);
    int b;
    b = x / BW;
    if (b > 7) b = 7;
    case (b)
      0:       return WHITE;
      1:       return YELLOW;
      2:       return CYAN;
      3:       return GREEN;
      4:       return MAGENTA;
      5:       return RED;
      6:       return BLUE;
      default: return BLACK;
    endcase
  endfunction

  typedef struct {
    int          x;
    logic [31:0] data;
    logic        last;
  } vec_t;

  vec_t vecs[14];

  logic        cap_v [FRAME+1];
  logic [31:0] cap_d [FRAME+1];
  logic        cap_u [FRAME+1];
  logic        cap_l [FRAME+1];

  initial begin
    int          cnt_v, cnt_l, cnt_u, err, n, bx, seq_err, hold_err;
    logic        found;
    logic [31:0] h_d;
    logic        h_u, h_l;

    vecs[0]  = '{0,  WHITE,   1'b0};
    vecs[1]  = '{4,  WHITE,   1'b0};
    vecs[2]  = '{5,  YELLOW,  1'b0};
    vecs[3]  = '{9,  YELLOW,  1'b0};
    vecs[4]  = '{10, CYAN,    1'b0};
    vecs[5]  = '{15, GREEN,   1'b0};
    vecs[6]  = '{20, MAGENTA, 1'b0};
    vecs[7]  = '{25, RED,     1'b0};
    vecs[8]  = '{30, BLUE,    1'b0};
    vecs[9]  = '{34, BLUE,    1'b0};
    vecs[10] = '{35, BLACK,   1'b0};
    vecs[11] = '{40, BLACK,   1'b0};
    vecs[12] = '{41, BLACK,   1'b0};
    vecs[13] = '{42, BLACK,   1'b1};

    vif.tready = 1'b1;

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst_tvalid", 32'(vif.tvalid), 32'd0);
    check("rst_tuser",  32'(vif.tuser),  32'd0);
    check("rst_tlast",  32'(vif.tlast),  32'd0);
    check("rst_tdata",  vif.tdata,       32'd0);
    check("tkeep",      32'(vif.tkeep),  32'hF);
    check("tstrb",      32'(vif.tstrb),  32'hF);
    check("tid",        32'(vif.tid),    32'd0);
    check("tdest",      32'(vif.tdest),  32'd0);

    // Release: valid must wait for the first edge.
    rst_n = 1'b1;
    #1;
    check("tvalid_before_edge", 32'(vif.tvalid), 32'd0);
    @(negedge clk);

    // Capture one full frame plus the first cycle of the next.
    for (int i = 0; i <= FRAME; i++) begin
      cap_v[i] = vif.tvalid;
      cap_d[i] = vif.tdata;
      cap_u[i] = vif.tuser;
      cap_l[i] = vif.tlast;
      if (i < FRAME) @(negedge clk);
    end

    check("first_tvalid", 32'(cap_v[0]), 32'd1);
    check("first_tuser",  32'(cap_u[0]), 32'd1);
    check("first_tdata",  cap_d[0],      WHITE);

    // Table vectors on the first and last active lines.
    for (int l = 0; l < YA; l += YA - 1) begin
      for (int j = 0; j < 14; j++) begin
        int idx;
        idx = l * XT + vecs[j].x;
        check($sformatf("vec_l%0d_x%0d_valid", l, vecs[j].x), 32'(cap_v[idx]), 32'd1);
        check($sformatf("vec_l%0d_x%0d_data",  l, vecs[j].x), cap_d[idx], vecs[j].data);
        check($sformatf("vec_l%0d_x%0d_last",  l, vecs[j].x), 32'(cap_l[idx]), 32'(vecs[j].last));
      end
    end

    // Whole-frame raster shape and content.
    cnt_v = 0; cnt_l = 0; cnt_u = 0; err = 0;
    for (int i = 0; i < FRAME; i++) begin
      logic ev, el;
      ev = ((i % XT) < XA) && ((i / XT) < YA);
      el = ev && ((i % XT) == XA - 1);
      if (cap_v[i]) cnt_v++;
      if (cap_l[i]) cnt_l++;
      if (cap_u[i]) cnt_u++;
      if (cap_v[i] !== ev || cap_l[i] !== el) err++;
      if (ev && cap_d[i] !== exp_pix(i % XT)) err++;
      if (!ev && cap_d[i] !== 32'd0) err++;
    end
    check("frame_valid_beats", 32'(cnt_v), 32'(XA * YA));
    check("frame_tlast_beats", 32'(cnt_l), 32'(YA));
    check("frame_tuser_beats", 32'(cnt_u), 32'd1);
    check("frame_raster_errs", 32'(err),   32'd0);
    check("next_frame_tuser",  32'(cap_u[FRAME]), 32'd1);
    check("next_frame_tdata",  cap_d[FRAME],      WHITE);

    // Backpressure: stall 10 clocks on the last yellow pixel (x=9).
    repeat (9) @(negedge clk);
    check("bp_tvalid_x9", 32'(vif.tvalid), 32'd1);
    check("bp_tdata_x9",  vif.tdata,       YELLOW);
    h_d = vif.tdata; h_u = vif.tuser; h_l = vif.tlast;
    vif.tready = 1'b0;
    hold_err = 0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (vif.tvalid !== 1'b1 || vif.tdata !== h_d || vif.tuser !== h_u || vif.tlast !== h_l)
        hold_err++;
    end
    check("bp_hold_errs", 32'(hold_err), 32'd0);
    vif.tready = 1'b1;
    n = 10; bx = 9; seq_err = 0; found = 1'b0;
    while (n < 200 && !found) begin
      @(negedge clk);
      n++;
      if (vif.tvalid) begin
        if (bx == XA - 1) begin
          found = 1'b1;
        end else begin
          bx++;
          if (vif.tdata !== exp_pix(bx)) seq_err++;
          if (vif.tlast !== (bx == XA - 1)) seq_err++;
        end
      end
    end
    check("bp_next_line_found", 32'(found), 32'd1);
    check("bp_line_clocks",     32'(n),     32'(XT - 9 + 10));
    check("bp_seq_errs",        32'(seq_err), 32'd0);
    check("bp_next_line_data",  vif.tdata,  WHITE);
    check("bp_next_line_tuser", 32'(vif.tuser), 32'd0);

    // Mid-line reset at line 3, x=20.
    repeat (2 * XT + 20) @(negedge clk);
    check("mid_tvalid", 32'(vif.tvalid), 32'd1);
    check("mid_tdata",  vif.tdata,       MAGENTA);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_tvalid", 32'(vif.tvalid), 32'd0);
    check("async_rst_tdata",  vif.tdata,       32'd0);
    check("async_rst_tuser",  32'(vif.tuser),  32'd0);
    check("async_rst_tlast",  32'(vif.tlast),  32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("restart_tvalid", 32'(vif.tvalid), 32'd1);
    check("restart_tuser",  32'(vif.tuser),  32'd1);
    check("restart_tdata",  vif.tdata,       WHITE);
    err = 0;
    for (int i = 1; i < XA; i++) begin
      @(negedge clk);
      if (vif.tvalid !== 1'b1 || vif.tuser !== 1'b0) err++;
      if (vif.tlast !== (i == XA - 1)) err++;
    end
    check("restart_line_errs", 32'(err), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
